// File: rtl/irq_ctrl.sv
// irq_ctrl: small interrupt controller with a bus register file.
// Sources are synchronised, classified as edge or level, masked, and the
// lowest pending unmasked index is presented to the CPU until software
// completes it or masks it off.
module irq_ctrl #(
  parameter int unsigned irq_n = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       addr,
  input  logic             we,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  input  logic [irq_n-1:0] irq_in,
  output logic             irq_out,
  output logic [4:0]       irq_id
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [irq_n-1:0] r_s1;
  logic [irq_n-1:0] r_s2;
  logic [irq_n-1:0] r_prev;
  logic [irq_n-1:0] r_mask;
  logic [irq_n-1:0] r_type;
  logic [irq_n-1:0] r_pend;
  logic [4:0]       r_irq_id;

  logic [2:0]       w_sel;
  logic             w_wr_mask;
  logic             w_wr_type;
  logic             w_wr_pend;
  logic             w_complete;
  logic [irq_n-1:0] w_rise;
  logic [irq_n-1:0] w_pend;
  logic [irq_n-1:0] w_type_nxt;
  logic [irq_n-1:0] w_clr;
  logic [irq_n-1:0] w_pend_nxt;
  logic             w_any;
  logic [4:0]       w_cand;
  logic [31:0]      w_mask32;
  logic             w_unused;

  assign w_sel     = addr[4:2];
  assign w_wr_mask = we && (w_sel == 3'd1);
  assign w_wr_type = we && (w_sel == 3'd2);
  assign w_wr_pend = we && (w_sel == 3'd3);
  assign w_complete = we && (w_sel == 3'd5) && (r_state == S_ACTIVE)
                   && (wd[4:0] == r_irq_id) && (32'(wd[4:0]) < irq_n);

  assign w_rise   = r_s2 & ~r_prev;
  // Level bits are never stored in r_pend, so the visible pending vector is
  // the stored edge bits merged with the live synchronised level bits.
  assign w_pend   = r_pend | (r_s2 & ~r_type);
  assign w_mask32 = 32'(r_mask);
  assign w_unused = ^{addr[1:0], wd};

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= irq_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // MASK and TYPE software registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mask <= '0;
      r_type <= '0;
    end else begin
      if (w_wr_mask) r_mask <= wd[irq_n-1:0];
      if (w_wr_type) r_type <= wd[irq_n-1:0];
    end
  end

  // Next value of the stored edge pending bits; set dominates clear, and a
  // bit only survives if it was edge-type before and after this edge, which
  // also zeroes it on a level-to-edge TYPE change.
  always_comb begin
    w_type_nxt = w_wr_type ? wd[irq_n-1:0] : r_type;
    w_clr      = '0;
    if (w_wr_pend) w_clr = wd[irq_n-1:0];
    for (int unsigned i = 0; i < irq_n; i++) begin
      if (w_complete && (r_irq_id == 5'(i))) w_clr[i] = 1'b1;
    end
    w_pend_nxt = r_type & w_type_nxt & (w_rise | (r_pend & ~w_clr));
  end

  // Edge pending storage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  // Lowest-index pending and unmasked source wins
  always_comb begin
    w_cand = '0;
    w_any  = 1'b0;
    for (int unsigned i = irq_n; i > 0; i--) begin
      if (w_pend[i-1] && r_mask[i-1]) begin
        w_cand = 5'(i - 1);
        w_any  = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_complete || !w_mask32[r_irq_id]) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Served index is captured only when leaving IDLE, so it is stable in ACTIVE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_irq_id <= '0;
    else if ((r_state == S_IDLE) && w_any) r_irq_id <= w_cand;
  end

  // FSM outputs decoded straight from the state flop
  always_comb begin
    irq_out = (r_state == S_ACTIVE);
    irq_id  = r_irq_id;
  end

  // Combinational register read mux
  always_comb begin
    rd = '0;
    case (w_sel)
      3'd0:    rd = 32'(r_s2);
      3'd1:    rd = 32'(r_mask);
      3'd2:    rd = 32'(r_type);
      3'd3:    rd = 32'(w_pend);
      3'd4:    rd = {(r_state == S_ACTIVE), 26'd0, r_irq_id};
      default: rd = '0;
    endcase
  end

endmodule
